// File: rtl/bus_xfer_scheduler.sv
// bus_xfer_scheduler: queues register-transfer requests from the control unit
// and the debug port, then sequences them onto the shared datapath bus as
// one-hot source strobes and one-hot destination load enables.
// MDR transfers hold the source strobe until memory reports ready.
// Optional feature macro: BUS_XFER_TRACE_EN adds saturating transfer/stall counters.
module bus_xfer_scheduler #(
  parameter int DEPTH = 4,
  parameter int NSRC  = 24,
  parameter int IDX_W = 5
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             cu_valid,
  input  logic [IDX_W-1:0] cu_src,
  input  logic [IDX_W-1:0] cu_dst,
  output logic             cu_ready,
  input  logic             dbg_valid,
  input  logic [IDX_W-1:0] dbg_src,
  input  logic [IDX_W-1:0] dbg_dst,
  output logic             dbg_ready,
  input  logic             mem_ready,
  output logic [NSRC-1:0]  src_out,
  output logic [NSRC-1:0]  dst_in,
  output logic             busy,
  output logic             err
`ifdef BUS_XFER_TRACE_EN
  ,
  output logic [15:0]      xfer_count,
  output logic [15:0]      stall_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] IDX_ZHI    = IDX_W'(18);
  localparam logic [IDX_W-1:0] IDX_ZLO    = IDX_W'(19);
  localparam logic [IDX_W-1:0] IDX_MDR    = IDX_W'(21);
  localparam logic [IDX_W-1:0] IDX_INPORT = IDX_W'(22);
  localparam logic [IDX_W-1:0] IDX_C      = IDX_W'(23);

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, WAIT = 2'd2} state_t;

  // Requests that would address a nonexistent register, load a read-only
  // destination, or move a register onto itself are rejected.
  function automatic logic is_illegal(input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] d);
    is_illegal = (int'(s) >= NSRC) || (int'(d) >= NSRC) ||
                 (d == IDX_ZHI) || (d == IDX_ZLO) || (d == IDX_INPORT) || (d == IDX_C) ||
                 (s == d);
  endfunction

  function automatic logic [NSRC-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = NSRC'(1) << i;
  endfunction

  logic [IDX_W-1:0] src_q [DEPTH];
  logic [IDX_W-1:0] dst_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             prio_r;      // 0: CU wins contention, 1: DBG wins
  logic             err_r;
  state_t           state_r;
  logic [NSRC-1:0]  dst_oh_r;
  logic             mdr_r;

  logic             full_s;
  logic             cu_gnt_s;
  logic             dbg_gnt_s;
  logic             acc_s;
  logic             push_s;
  logic             pop_s;
  logic             active_s;
  logic             complete_s;
  logic [IDX_W-1:0] req_src_s;
  logic [IDX_W-1:0] req_dst_s;
  logic [IDX_W-1:0] head_src_s;
  logic [IDX_W-1:0] head_dst_s;

  // Arbitration, acceptance and transfer-completion decode.
  always_comb begin
    full_s     = (count_r == CNT_W'(DEPTH));
    cu_ready   = !full_s && !(dbg_valid && prio_r);
    dbg_ready  = !full_s && !(cu_valid && !prio_r);
    cu_gnt_s   = cu_valid && cu_ready;
    dbg_gnt_s  = dbg_valid && dbg_ready;
    acc_s      = cu_gnt_s || dbg_gnt_s;
    if (cu_gnt_s) begin
      req_src_s = cu_src;
      req_dst_s = cu_dst;
    end else begin
      req_src_s = dbg_src;
      req_dst_s = dbg_dst;
    end
    push_s     = acc_s && !is_illegal(req_src_s, req_dst_s);
    active_s   = (state_r != IDLE);
    // An MDR transfer only completes in a cycle where memory is ready.
    complete_s = active_s && (!mdr_r || mem_ready);
    pop_s      = (count_r != CNT_W'(0)) && (!active_s || complete_s);
    head_src_s = src_q[rd_ptr_r];
    head_dst_s = dst_q[rd_ptr_r];
    // The load enable is qualified in the same cycle memory answers.
    if (complete_s) begin
      dst_in = dst_oh_r;
    end else begin
      dst_in = '0;
    end
    busy = (count_r != CNT_W'(0)) || active_s;
    err  = err_r;
  end

  // Request FIFO, round-robin pointer and illegal-request error pulse.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      prio_r   <= 1'b0;
      err_r    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
      end
    end else begin
      err_r <= acc_s && !push_s;
      if (cu_valid && dbg_valid && !full_s) begin
        prio_r <= !prio_r;
      end
      if (push_s) begin
        src_q[wr_ptr_r] <= req_src_s;
        dst_q[wr_ptr_r] <= req_dst_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Transfer sequencer: loads the FIFO head into the strobe registers and
  // holds MDR transfers until memory completes them.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_r  <= IDLE;
      src_out  <= '0;
      dst_oh_r <= '0;
      mdr_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DRIVE, WAIT: begin
          if (pop_s) begin
            state_r  <= DRIVE;
            src_out  <= onehot(head_src_s);
            dst_oh_r <= onehot(head_dst_s);
            mdr_r    <= (head_src_s == IDX_MDR) || (head_dst_s == IDX_MDR);
          end else if (active_s && !complete_s) begin
            state_r <= WAIT;
          end else begin
            state_r  <= IDLE;
            src_out  <= '0;
            dst_oh_r <= '0;
            mdr_r    <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          src_out  <= '0;
          dst_oh_r <= '0;
          mdr_r    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_XFER_TRACE_EN
  // Saturating counters of completed transfers and memory stall cycles.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      xfer_count  <= 16'h0000;
      stall_count <= 16'h0000;
    end else begin
      if (complete_s && (xfer_count != 16'hFFFF)) begin
        xfer_count <= xfer_count + 16'h0001;
      end
      if ((state_r == WAIT) && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_xfer_scheduler.sv
// Self-checking bench for bus_xfer_scheduler: directed scenarios plus a
// randomized run, all checked against a queue-based transfer model.
module tb_bus_xfer_scheduler;

  localparam int DEPTH = 4;

  logic        clock;
  logic        clear_n;
  logic        cu_valid;
  logic [4:0]  cu_src;
  logic [4:0]  cu_dst;
  logic        cu_ready;
  logic        dbg_valid;
  logic [4:0]  dbg_src;
  logic [4:0]  dbg_dst;
  logic        dbg_ready;
  logic        mem_ready;
  logic [23:0] src_out;
  logic [23:0] dst_in;
  logic        busy;
  logic        err;
`ifdef BUS_XFER_TRACE_EN
  logic [15:0] xfer_count;
  logic [15:0] stall_count;
`endif

  int total = 0;
  int bad   = 0;

  bus_xfer_scheduler dut (
    .clock(clock), .clear_n(clear_n),
    .cu_valid(cu_valid), .cu_src(cu_src), .cu_dst(cu_dst), .cu_ready(cu_ready),
    .dbg_valid(dbg_valid), .dbg_src(dbg_src), .dbg_dst(dbg_dst), .dbg_ready(dbg_ready),
    .mem_ready(mem_ready), .src_out(src_out), .dst_in(dst_in), .busy(busy), .err(err)
`ifdef BUS_XFER_TRACE_EN
    , .xfer_count(xfer_count), .stall_count(stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int q_src[$];
  int q_dst[$];
  bit m_cur_v;
  int m_cur_src, m_cur_dst, m_age;
  bit m_err, m_prio;
  int m_xfers, m_stalls;

  logic [23:0] obs_src, obs_dst, exp_src, exp_dst;
  logic obs_busy, obs_err, obs_cu_rdy, obs_dbg_rdy;
  logic exp_busy, exp_err, exp_cu_rdy, exp_dbg_rdy;
  int cyc = 0;

  function automatic bit legal(input int s, input int d);
    return (s < 24) && (d < 24) && !(d inside {18, 19, 22, 23}) && (s != d);
  endfunction

  function automatic logic [23:0] bit_of(input int i);
    logic [23:0] v;
    v = 24'd0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    q_src.delete(); q_dst.delete();
    m_cur_v = 0; m_age = 0; m_err = 0; m_prio = 0;
  endtask

  task automatic model_edge();
    bit full, cu_g, dbg_g, done, mdr;
    int s, d;
    full  = (q_src.size() == DEPTH);
    cu_g  = cu_valid && !full && !(dbg_valid && m_prio);
    dbg_g = dbg_valid && !full && !(cu_valid && !m_prio);
    s = cu_g ? int'(cu_src) : int'(dbg_src);
    d = cu_g ? int'(cu_dst) : int'(dbg_dst);
    mdr  = (m_cur_src == 21) || (m_cur_dst == 21);
    done = m_cur_v && (!mdr || mem_ready);
    if (done) m_xfers++;
    if (m_cur_v && m_age > 0) m_stalls++;
    if (!m_cur_v || done) begin
      if (q_src.size() > 0) begin
        m_cur_src = q_src.pop_front();
        m_cur_dst = q_dst.pop_front();
        m_cur_v = 1; m_age = 0;
      end else begin
        m_cur_v = 0;
      end
    end else begin
      m_age++;
    end
    if ((cu_g || dbg_g) && legal(s, d)) begin
      q_src.push_back(s);
      q_dst.push_back(d);
    end
    m_err = (cu_g || dbg_g) && !legal(s, d);
    if (cu_valid && dbg_valid && !full) m_prio = !m_prio;
  endtask

  // Advance one cycle: sample DUT and model expectations mid-cycle, then clock the model.
  task automatic step();
    bit full, mdr;
    @(negedge clock);
    obs_src = src_out; obs_dst = dst_in; obs_busy = busy; obs_err = err;
    obs_cu_rdy = cu_ready; obs_dbg_rdy = dbg_ready;
    full = (q_src.size() == DEPTH);
    mdr  = (m_cur_src == 21) || (m_cur_dst == 21);
    exp_src = m_cur_v ? bit_of(m_cur_src) : 24'd0;
    exp_dst = (m_cur_v && (!mdr || mem_ready)) ? bit_of(m_cur_dst) : 24'd0;
    exp_busy = (q_src.size() != 0) || m_cur_v;
    exp_err = m_err;
    exp_cu_rdy  = !full && !(dbg_valid && m_prio);
    exp_dbg_rdy = !full && !(cu_valid && !m_prio);
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    cu_valid = 0; dbg_valid = 0; cu_src = 5'd0; cu_dst = 5'd0;
    dbg_src = 5'd0; dbg_dst = 5'd0; mem_ready = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    clear_n = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    total++; if (src_out !== 24'd0) begin bad++; $display("FAIL reset_src got %h want 0", src_out); end
    total++; if (dst_in !== 24'd0) begin bad++; $display("FAIL reset_dst got %h want 0", dst_in); end
    total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_busy_err got %b%b want 00", busy, err); end
    clear_n = 1;
    step();
    total++; if (obs_cu_rdy !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", obs_cu_rdy); end
  endtask

  task automatic test_single();
    cu_valid = 1; cu_src = 5'd4; cu_dst = 5'd16;
    step();
    cu_valid = 0;
    step();
    total++; if (obs_src !== 24'd0) begin bad++; $display("FAIL single_lat1 got %h want 0", obs_src); end
    step();
    total++; if (obs_src !== 24'h000010) begin bad++; $display("FAIL single_src got %h want 000010", obs_src); end
    total++; if (obs_dst !== 24'h010000) begin bad++; $display("FAIL single_dst got %h want 010000", obs_dst); end
    step();
    total++; if (obs_src !== 24'd0 || obs_busy !== 1'b0) begin bad++; $display("FAIL single_done got src=%h busy=%b want 0/0", obs_src, obs_busy); end
  endtask

  task automatic test_mdr_wait();
    int n_src = 0, n_dst = 0;
    cu_valid = 1; cu_src = 5'd21; cu_dst = 5'd2; mem_ready = 0;
    step();
    cu_valid = 0;
    for (int k = 1; k <= 7; k++) begin
      mem_ready = (k >= 5);
      step();
      if (obs_src === 24'h200000) n_src++;
      if (obs_dst === 24'h000004) begin
        n_dst++;
        total++; if (k != 5) begin bad++; $display("FAIL mdr_dst_cycle got %0d want 5", k); end
      end
      total++; if (obs_src !== exp_src || obs_dst !== exp_dst) begin bad++; $display("FAIL mdr_strobes got %h/%h want %h/%h", obs_src, obs_dst, exp_src, exp_dst); end
    end
    total++; if (n_src != 4) begin bad++; $display("FAIL mdr_src_len got %0d want 4", n_src); end
    total++; if (n_dst != 1) begin bad++; $display("FAIL mdr_dst_len got %0d want 1", n_dst); end
  endtask

  task automatic test_illegal();
    cu_valid = 1; cu_src = 5'd5; cu_dst = 5'd18;
    step();
    total++; if (obs_cu_rdy !== 1'b1) begin bad++; $display("FAIL illegal_rdy1 got %b want 1", obs_cu_rdy); end
    cu_src = 5'd7; cu_dst = 5'd7;
    step();
    total++; if (obs_cu_rdy !== 1'b1 || obs_err !== 1'b1) begin bad++; $display("FAIL illegal_err1 got rdy=%b err=%b want 1/1", obs_cu_rdy, obs_err); end
    cu_valid = 0;
    step();
    total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL illegal_err2 got %b want 1", obs_err); end
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (obs_err !== 1'b0 || obs_src !== 24'd0 || obs_dst !== 24'd0 || obs_busy !== 1'b0) begin
        bad++; $display("FAIL illegal_quiet got err=%b src=%h dst=%h busy=%b want 0", obs_err, obs_src, obs_dst, obs_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Stall an MDR transfer so both requesters fill the FIFO.
    mem_ready = 0;
    cu_valid = 1; dbg_valid = 1;
    for (int k = 0; k < 8; k++) begin
      cu_src  = (k == 0) ? 5'd21 : 5'(k);      cu_dst  = 5'd3;
      dbg_src = 5'(8 + k);                     dbg_dst = 5'd16;
      step();
      total++; if (obs_cu_rdy !== exp_cu_rdy || obs_dbg_rdy !== exp_dbg_rdy) begin
        bad++; $display("FAIL b2b_ready k=%0d got %b%b want %b%b", k, obs_cu_rdy, obs_dbg_rdy, exp_cu_rdy, exp_dbg_rdy);
      end
    end
    total++; if (obs_cu_rdy !== 1'b0 || obs_dbg_rdy !== 1'b0) begin bad++; $display("FAIL b2b_full got %b%b want 00", obs_cu_rdy, obs_dbg_rdy); end
    cu_valid = 0; dbg_valid = 0; mem_ready = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      total++; if (obs_src !== exp_src || obs_dst !== exp_dst || obs_busy !== exp_busy) begin
        bad++; $display("FAIL b2b_drain k=%0d got %h/%h/%b want %h/%h/%b", k, obs_src, obs_dst, obs_busy, exp_src, exp_dst, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    cu_valid = 1; cu_src = 5'd21; cu_dst = 5'd2; mem_ready = 0;
    step();
    cu_src = 5'd1; cu_dst = 5'd2;
    step();
    cu_valid = 0;
    step(); step();
    total++; if (obs_src !== 24'h200000) begin bad++; $display("FAIL rmid_pre got %h want 200000", obs_src); end
    #2 clear_n = 0;
    #1;
    total++; if (src_out !== 24'd0 || dst_in !== 24'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_drop got src=%h dst=%h busy=%b want 0", src_out, dst_in, busy);
    end
    model_reset();
    @(posedge clock); #3;
    clear_n = 1;
    mem_ready = 1;
    cu_valid = 1; dbg_valid = 1;
    cu_src = 5'd9; cu_dst = 5'd10; dbg_src = 5'd11; dbg_dst = 5'd12;
    step();
    total++; if (obs_cu_rdy !== 1'b1 || obs_dbg_rdy !== 1'b0 || obs_busy !== 1'b0) begin
      bad++; $display("FAIL rmid_grant got cu=%b dbg=%b busy=%b want 1/0/0", obs_cu_rdy, obs_dbg_rdy, obs_busy);
    end
    cu_valid = 0; dbg_valid = 0;
    step(); step();
    total++; if (obs_src !== 24'h000200) begin bad++; $display("FAIL rmid_first got %h want 000200", obs_src); end
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      cu_valid  = ($urandom_range(0, 2) != 0);
      dbg_valid = ($urandom_range(0, 2) == 0);
      cu_src  = ($urandom_range(0, 5) == 0) ? 5'd21 : 5'($urandom_range(0, 23));
      cu_dst  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 17));
      dbg_src = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
      dbg_dst = ($urandom_range(0, 5) == 0) ? 5'd21 : 5'($urandom_range(0, 23));
      mem_ready = ($urandom_range(0, 3) != 0);
      step();
      total++; if (obs_src !== exp_src) begin bad++; $display("FAIL rnd_src cyc=%0d got %h want %h", cyc, obs_src, exp_src); end
      total++; if (obs_dst !== exp_dst) begin bad++; $display("FAIL rnd_dst cyc=%0d got %h want %h", cyc, obs_dst, exp_dst); end
      total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got %b want %b", cyc, obs_busy, exp_busy); end
      total++; if (obs_err !== exp_err) begin bad++; $display("FAIL rnd_err cyc=%0d got %b want %b", cyc, obs_err, exp_err); end
      total++; if (obs_cu_rdy !== exp_cu_rdy) begin bad++; $display("FAIL rnd_cu_rdy cyc=%0d got %b want %b", cyc, obs_cu_rdy, exp_cu_rdy); end
      total++; if (obs_dbg_rdy !== exp_dbg_rdy) begin bad++; $display("FAIL rnd_dbg_rdy cyc=%0d got %b want %b", cyc, obs_dbg_rdy, exp_dbg_rdy); end
    end
    idle_inputs();
    repeat (30) step();
  endtask

`ifdef BUS_XFER_TRACE_EN
  task automatic test_trace();
    m_xfers = 0; m_stalls = 0;
    clear_n = 0; model_reset();
    @(posedge clock); #3;
    clear_n = 1;
    for (int k = 0; k < 10; k++) begin
      cu_valid = 1; cu_src = (k == 3) ? 5'd21 : 5'(k + 1); cu_dst = 5'd16;
      mem_ready = 1;
      step();
    end
    cu_valid = 0;
    for (int k = 0; k < 20; k++) begin
      mem_ready = !(k >= 2 && k < 5);
      step();
    end
    total++; if (xfer_count !== 16'(m_xfers) || m_xfers != 10) begin bad++; $display("FAIL trace_xfer got %0d want %0d(10)", xfer_count, m_xfers); end
    total++; if (stall_count !== 16'(m_stalls)) begin bad++; $display("FAIL trace_stall got %0d want %0d", stall_count, m_stalls); end
  endtask
`endif

  initial begin
    m_xfers = 0; m_stalls = 0; m_cur_src = 0; m_cur_dst = 0;
    test_reset();
    test_single();
    test_mdr_wait();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef BUS_XFER_TRACE_EN
    test_trace();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
